// File: rtl/pulse_tx_pkg.sv
// Shared constants and state encoding for the pulse transmitter and the receive-side shaper.
package pulse_tx_pkg;

  localparam int DEF_PREAMBLE_SIZE  = 8;
  localparam int DEF_PACKET_SIZE    = 24;
  localparam int DEF_PULSE_INTERVAL = 10000;
  localparam int DEF_PULSE_WIDTH    = 4;

  localparam int SLOT_CNT_W = 14;
  localparam int SLOT_IDX_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_DATA     = 3'd3,
    ST_DONE     = 3'd4
  } tx_state_t;

  // An external slot must be able to hold a pulse plus an equally long gap.
  function automatic logic [SLOT_CNT_W-1:0] select_slot_len(
    input logic                  use_ext,
    input logic [SLOT_CNT_W-1:0] ext_len,
    input logic [SLOT_CNT_W-1:0] min_len,
    input logic [SLOT_CNT_W-1:0] def_len
  );
    return (use_ext && (ext_len >= min_len)) ? ext_len : def_len;
  endfunction

endpackage

// File: rtl/pulse_tx_slot_timer.sv
// Slot counter: runs 0..len-1 while enabled, flags the last cycle of a slot and
// reports whether the next cycle falls inside the pulse window.
module slot_timer
  import pulse_tx_pkg::*;
#(
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [SLOT_CNT_W-1:0] len,
  output logic                  boundary,
  output logic                  window_next
);

  localparam logic [SLOT_CNT_W-1:0] WIDTH_CNT = SLOT_CNT_W'(PULSE_WIDTH);

  logic [SLOT_CNT_W-1:0] cnt;
  logic [SLOT_CNT_W-1:0] cnt_next;

  always_comb begin
    boundary    = run && (cnt == (len - 14'd1));
    cnt_next    = (!run || boundary) ? '0 : cnt + 14'd1;
    window_next = (cnt_next < WIDTH_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/pulse_tx.sv
// OOK pulse transmitter: a fixed preamble of pulses followed by one payload bit per slot,
// MSB first. All outputs are registered from next-state values.
module pulse_tx
  import pulse_tx_pkg::*;
#(
  parameter int PREAMBLE_SIZE  = DEF_PREAMBLE_SIZE,
  parameter int PACKET_SIZE    = DEF_PACKET_SIZE,
  parameter int PULSE_INTERVAL = DEF_PULSE_INTERVAL,
  parameter int PULSE_WIDTH    = DEF_PULSE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PACKET_SIZE-1:0] data_in,
  input  logic                  ext_interval_flag,
  input  logic [SLOT_CNT_W-1:0] ext_interval,
  output logic                  rfout,
  output logic                  tx_rdy,
  output logic                  busy,
  output logic                  done
);

  localparam logic [SLOT_CNT_W-1:0] MIN_EXT_LEN = SLOT_CNT_W'(2 * PULSE_WIDTH);
  localparam logic [SLOT_CNT_W-1:0] DEF_LEN     = SLOT_CNT_W'(PULSE_INTERVAL);
  localparam logic [SLOT_IDX_W-1:0] LAST_PRE    = SLOT_IDX_W'(PREAMBLE_SIZE - 1);
  localparam logic [SLOT_IDX_W-1:0] LAST_DATA   = SLOT_IDX_W'(PACKET_SIZE - 1);

  tx_state_t              state, state_next;
  logic [SLOT_IDX_W-1:0]  slot_idx, slot_idx_next;
  logic [PACKET_SIZE-1:0] shreg, shreg_next;
  logic [SLOT_CNT_W-1:0]  len, len_next;
  logic                   slot_run, boundary, window_next;
  logic                   rfout_next, tx_rdy_next, busy_next, done_next;

  assign slot_run = (state == ST_PREAMBLE) || (state == ST_DATA);

  slot_timer #(
    .PULSE_WIDTH(PULSE_WIDTH)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (slot_run),
    .len        (len),
    .boundary   (boundary),
    .window_next(window_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      slot_idx <= '0;
      shreg    <= '0;
      len      <= '0;
      rfout    <= 1'b0;
      tx_rdy   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      slot_idx <= slot_idx_next;
      shreg    <= shreg_next;
      len      <= len_next;
      rfout    <= rfout_next;
      tx_rdy   <= tx_rdy_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    slot_idx_next = slot_idx;
    shreg_next    = shreg;
    len_next      = len;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next = ST_LOAD;
          shreg_next = data_in;
          len_next   = select_slot_len(ext_interval_flag, ext_interval, MIN_EXT_LEN, DEF_LEN);
        end
      end
      ST_LOAD: begin
        state_next    = ST_PREAMBLE;
        slot_idx_next = '0;
      end
      ST_PREAMBLE: begin
        if (boundary) begin
          if (slot_idx == LAST_PRE) begin
            state_next    = ST_DATA;
            slot_idx_next = '0;
          end else begin
            slot_idx_next = slot_idx + 6'd1;
          end
        end
      end
      ST_DATA: begin
        if (boundary) begin
          shreg_next = {shreg[PACKET_SIZE-2:0], 1'b0};
          if (slot_idx == LAST_DATA) begin
            state_next    = ST_DONE;
            slot_idx_next = '0;
          end else begin
            slot_idx_next = slot_idx + 6'd1;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // Abort overrides whatever transition the state would otherwise take.
    if (abort && (state != ST_IDLE)) begin
      state_next    = ST_IDLE;
      slot_idx_next = '0;
    end
  end

  // Decode from next-state values so each registered output lines up with its state.
  always_comb begin
    rfout_next  = window_next &&
                  ((state_next == ST_PREAMBLE) ||
                   ((state_next == ST_DATA) && shreg_next[PACKET_SIZE-1]));
    tx_rdy_next = (state_next == ST_LOAD);
    busy_next   = (state_next != ST_IDLE);
    done_next   = (state_next == ST_DONE);
  end

endmodule

// File: tb/tb_pulse_tx.sv
// Self-checking bench for pulse_tx: a frame-position reference model predicts
// rfout/tx_rdy/busy/done every cycle under directed and random stimulus.
module tb_pulse_tx;

  localparam int PRE     = 8;
  localparam int PKT     = 24;
  localparam int PW      = 4;
  localparam int DEF_INT = 10000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        ext_interval_flag;
  logic [13:0] ext_interval;
  logic [23:0] data_in;
  logic        rfout, tx_rdy, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  logic prev_rf = 1'b0;

  // Reference model: a frame is just "cycles since LOAD" plus the latched data and length.
  bit          m_active = 1'b0;
  int          m_k      = 0;
  int          m_len    = 0;
  logic [23:0] m_data   = '0;

  pulse_tx dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .data_in          (data_in),
    .ext_interval_flag(ext_interval_flag),
    .ext_interval     (ext_interval),
    .rfout            (rfout),
    .tx_rdy           (tx_rdy),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic [3:0] model_outs();
    int   slot;
    int   off;
    logic rf;
    rf = 1'b0;
    if (!m_active) return 4'b0000;
    if (m_k >= 1 && m_k <= (PRE + PKT) * m_len) begin
      slot = (m_k - 1) / m_len;
      off  = (m_k - 1) % m_len;
      if (off < PW) rf = (slot < PRE) ? 1'b1 : m_data[PKT - 1 - (slot - PRE)];
    end
    return {rf, (m_k == 0), 1'b1, (m_k == 1 + (PRE + PKT) * m_len)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs mid-cycle, drive new inputs, then advance the model at the edge.
  task automatic applyStimulus(input string tag, input logic s, input logic a, input logic r,
                               input logic f, input logic [13:0] e, input logic [23:0] d);
    logic [3:0] obs;
    @(negedge clk);
    obs = {rfout, tx_rdy, busy, done};
    checkOutput(tag, {28'd0, obs}, {28'd0, model_outs()});
    if (rfout && !prev_rf) rise_cnt++;
    prev_rf = rfout;
    if (done) done_cnt++;
    start             = s;
    abort             = a;
    rst               = r;
    ext_interval_flag = f;
    ext_interval      = e;
    data_in           = d;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (a || (m_k == 1 + (PRE + PKT) * m_len)) m_active = 1'b0;
      else m_k++;
    end else if (s && !a) begin
      m_active = 1'b1;
      m_k      = 0;
      m_data   = d;
      m_len    = (f && (int'(e) >= 2 * PW)) ? int'(e) : DEF_INT;
    end
  endtask

  initial begin
    logic [23:0] d27;
    logic        rs, ra, rr;
    rst               = 1'b1;
    start             = 1'b0;
    abort             = 1'b0;
    ext_interval_flag = 1'b0;
    ext_interval      = '0;
    data_in           = '0;
    repeat (2) @(posedge clk);

    repeat (3) applyStimulus("reset", 1'b1, 1'b1, 1'b1, 1'b1, 14'd20, 24'hFFFFFF);
    repeat (2) applyStimulus("idle", 1'b0, 1'b0, 1'b0, 1'b1, 14'd20, 24'h0);

    // Nominal frame; ext_interval wanders mid-frame and must not be re-sampled.
    rise_cnt = 0; done_cnt = 0;
    applyStimulus("a5_start", 1'b1, 1'b0, 1'b0, 1'b1, 14'd20, 24'hA5A5A5);
    repeat (1 + 32 * 20 + 3)
      applyStimulus("a5_frame", 1'b0, 1'b0, 1'b0, 1'b1, 14'($urandom_range(0, 40)), 24'($urandom));
    checkOutput("a5_pulses", rise_cnt, 32'(PRE + 12));
    checkOutput("a5_done", done_cnt, 32'd1);

    // Abort in DATA slot 3 while the pulse for bit 20 is high.
    rise_cnt = 0; done_cnt = 0;
    applyStimulus("abort_start", 1'b1, 1'b0, 1'b0, 1'b1, 14'd20, 24'h100000);
    repeat (222) applyStimulus("abort_run", 1'b0, 1'b0, 1'b0, 1'b1, 14'd20, 24'h0);
    applyStimulus("abort_hit", 1'b0, 1'b1, 1'b0, 1'b1, 14'd20, 24'h0);
    repeat (5) applyStimulus("abort_after", 1'b0, 1'b0, 1'b0, 1'b1, 14'd20, 24'h0);
    checkOutput("abort_no_done", done_cnt, 32'd0);

    // Reset during a preamble pulse, then a full frame at the shortest legal slot.
    applyStimulus("rst_start", 1'b1, 1'b0, 1'b0, 1'b1, 14'd20, 24'h123456);
    repeat (2) applyStimulus("rst_run", 1'b0, 1'b0, 1'b0, 1'b1, 14'd20, 24'h0);
    applyStimulus("rst_hit", 1'b1, 1'b1, 1'b1, 1'b1, 14'd20, 24'h0);
    repeat (2) applyStimulus("rst_after", 1'b0, 1'b0, 1'b0, 1'b1, 14'd20, 24'h0);
    rise_cnt = 0; done_cnt = 0; prev_rf = 1'b0;
    d27 = 24'($urandom);
    applyStimulus("rst_frame_start", 1'b1, 1'b0, 1'b0, 1'b1, 14'd8, d27);
    repeat (1 + 32 * 8 + 3) applyStimulus("rst_frame", 1'b0, 1'b0, 1'b0, 1'b1, 14'd8, 24'h0);
    checkOutput("rst_frame_pulses", rise_cnt, 32'(PRE + $countones(d27)));
    checkOutput("rst_frame_done", done_cnt, 32'd1);

    // Too-short external slot falls back to the default interval.
    rise_cnt = 0;
    applyStimulus("fallback_start", 1'b1, 1'b0, 1'b0, 1'b1, 14'd5, 24'hFFFFFF);
    repeat (10010)
      applyStimulus("fallback_run", 1'b0, 1'b0, 1'b0, 1'b1, 14'($urandom_range(8, 30)), 24'h0);
    checkOutput("fallback_pulses", rise_cnt, 32'd2);
    applyStimulus("fallback_abort", 1'b0, 1'b1, 1'b0, 1'b1, 14'd20, 24'h0);
    repeat (3) applyStimulus("fallback_after", 1'b0, 1'b0, 1'b0, 1'b1, 14'd20, 24'h0);

    // Abort together with start in IDLE must not launch a frame.
    applyStimulus("abort_and_start", 1'b1, 1'b1, 1'b0, 1'b1, 14'd20, 24'hFFFFFF);
    repeat (2) applyStimulus("abort_and_start_after", 1'b0, 1'b0, 1'b0, 1'b1, 14'd20, 24'h0);

    // Start held high: back-to-back frames with a single IDLE cycle between them.
    rise_cnt = 0; done_cnt = 0;
    repeat (643 * 3 + 2) applyStimulus("held_start", 1'b1, 1'b0, 1'b0, 1'b1, 14'd20, 24'hFFFFFF);
    checkOutput("held_done", done_cnt, 32'd3);
    checkOutput("held_pulses", rise_cnt, 32'd96);
    applyStimulus("held_stop", 1'b0, 1'b1, 1'b0, 1'b1, 14'd20, 24'h0);

    // Random traffic with occasional abort and reset.
    for (int i = 0; i < 15000; i++) begin
      rs = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 699) == 0);
      rr = ($urandom_range(0, 2999) == 0);
      applyStimulus("random", rs, ra, rr, 1'b1, 14'($urandom_range(8, 24)), 24'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
